imager_stream_parser: RTL and testbench
=======================================

// Module: imager_stream_parser
// PURPOSE
//  Parametrised successor to the single-frame imager parser with date overlay.
//  Parses a per-frame dimension header, then a pixel stream of CHANNELS
//  components per pixel, each DW bits wide. Overlays a programmable 1-bit
//  bitmap at a programmable position, emits a qualified component stream with
//  frame/line markers, then re-arms for the next frame (multi-frame).
//  Sits between the imager input and the colour-conversion/DCT chain.
// PARAMETERS
//  DW        8      component / input beat width, bits (DW >= 8)
//  CHANNELS  3      components per pixel (1..4)
//  DIM_W     32     dimension width; must be a multiple of DW
//  OV_W      64     overlay bitmap width, pixels
//  OV_H      8      overlay bitmap height, pixels
//  OV_FG     8'hFF  value written to every component of a set bitmap pixel (DW bits)
// PORTS
//  clk_in           in   1              clock, rising edge
//  rst              in   1              asynchronous reset, active-high
//  pxq              in   1              d_in qualifier; beat accepted when high
//  d_in             in   DW             header beat or pixel component
//  ov_en            in   1              overlay enable
//  ov_x             in   DIM_W          overlay left column
//  ov_y             in   DIM_W          overlay top row
//  ov_bitmap        in   OV_W*OV_H      bitmap; bit index = row*OV_W + col
//  line_width       out  DIM_W          parsed width, pixels
//  pic_height       out  DIM_W          parsed height, lines
//  dimensions_valid out  1              width/height valid for current frame
//  d_qual           out  1              dout valid this cycle
//  dout             out  DW             component out
//  chan             out  2              component index of dout (0..CHANNELS-1)
//  sof / eol / eof  out  1 each         qualified with d_qual: first component of frame / last component of line / last component of frame
//  frame_cnt        out  16             completed frames, wraps at 2^16
// BEHAVIOUR
//  Reset: all outputs 0; FSM in HDR_W; all counters 0.
//  FSM (advances only on pxq=1; pxq=0 holds all state, d_qual=0 next cycle):
//   HDR_W : DIM_W/DW beats, MSB first, shifted into width -> HDR_H
//   HDR_H : DIM_W/DW beats, MSB first, into height. On last beat:
//           width==0 or height==0 -> HDR_W, frame dropped, frame_cnt unchanged;
//           else dimensions_valid=1, ov_en/ov_x/ov_y latched -> PIX
//   PIX   : counters ch (0..CHANNELS-1), x (0..width-1), y (0..height-1);
//           ch wraps -> x++; x wraps -> y++; last component -> HDR_W,
//           frame_cnt++
//  dimensions_valid: rises with the last HDR_H beat; falls when the first
//   HDR_W beat of the next frame is accepted. line_width/pic_height update only
//   on that last beat; they never show partially shifted values.
//  Header beats never produce d_qual.
//  Output latency: exactly 1 cycle from an accepted PIX beat to d_qual=1 with
//   registered dout/chan/sof/eol/eof. d_qual is a single-cycle pulse per beat.
//  Overlay:
//   - active when latched ov_en=1 and ov_x <= x < ov_x+OV_W and
//     ov_y <= y < ov_y+OV_H; compare uses DIM_W+1-bit sums so no wrap
//   - active pixel with bitmap[(y-ov_y)*OV_W + (x-ov_x)]=1: every component
//     output = OV_FG; otherwise d_in passes unchanged
//   - rectangle partly outside the picture is clipped; no error
//   - ov_bitmap is sampled live, so the driver holds it stable per frame
//  Markers: sof = (x==0 && y==0 && ch==0); eol = (x==width-1 && ch==CHANNELS-1);
//   eof = eol && y==height-1.
//  Boundaries:
//   - width=1: every pixel ends a line
//   - height=1: eol and eof coincide on the last component
//   - frame_cnt wraps 0xFFFF -> 0
//   - a new frame's header may start the cycle after eof
//   - rst mid-frame: immediate return to reset state; the next accepted beat
//     is the first width beat
// TESTING
//  1. Header w=4,h=2, CHANNELS=3, 24 beats 0..23, pxq=1 -> d_qual 24 cycles;
//     dout 0..23 one cycle late; sof on beat 0; eol on beats 11,23; eof on beat 23;
//     frame_cnt=1.
//  2. Same frame with pxq toggling 1/0 -> identical dout sequence; counters
//     frozen on pxq=0 cycles; d_qual=0 on those cycles.
//  3. ov_en=1, ov_x=1, ov_y=1, bitmap bit0=1 (OV_W=64), w=4,h=2 -> only pixel
//     (1,1) components = 8'hFF; all others unchanged.
//  4. Header w=0,h=5 followed by valid header w=2,h=1 -> first frame dropped;
//     dimensions_valid only for the second; frame_cnt=1.
//  5. Two back-to-back frames -> dimensions_valid falls on the 2nd frame's first
//     header beat; frame_cnt=2; sof asserted once per frame.
//  6. rst pulse mid-PIX -> all outputs 0; a fresh header is parsed correctly.

Source files
------------

// File: rtl/imager_stream_parser.sv
// Imager stream parser: per-frame width/height header, CHANNELS-component pixel stream,
// 1-bit bitmap overlay at a latched position, frame/line markers, multi-frame operation.
module imager_stream_parser #(
    parameter int unsigned   DW       = 8,
    parameter int unsigned   CHANNELS = 3,
    parameter int unsigned   DIM_W    = 32,
    parameter int unsigned   OV_W     = 64,
    parameter int unsigned   OV_H     = 8,
    parameter logic [DW-1:0] OV_FG    = DW'(8'hFF)
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 pxq,
    input  logic [DW-1:0]        d_in,
    input  logic                 ov_en,
    input  logic [DIM_W-1:0]     ov_x,
    input  logic [DIM_W-1:0]     ov_y,
    input  logic [OV_W*OV_H-1:0] ov_bitmap,
    output logic [DIM_W-1:0]     line_width,
    output logic [DIM_W-1:0]     pic_height,
    output logic                 dimensions_valid,
    output logic                 d_qual,
    output logic [DW-1:0]        dout,
    output logic [1:0]           chan,
    output logic                 sof,
    output logic                 eol,
    output logic                 eof,
    output logic [15:0]          frame_cnt
);

    localparam int unsigned HB    = DIM_W / DW;
    localparam int unsigned HB_W  = (HB > 1) ? $clog2(HB) : 1;
    localparam int unsigned IDX_W = (OV_W * OV_H > 1) ? $clog2(OV_W * OV_H) : 1;

    typedef logic [DIM_W:0] ext_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic [1:0] {StHdrW, StHdrH, StPix} state_e;

    state_e           state_q, state_d;
    logic [HB_W-1:0]  hb_q, hb_d;
    logic [DIM_W-1:0] w_sh_q, w_sh_d, h_sh_q, h_sh_d, h_full;
    logic [DIM_W-1:0] width_q, width_d, height_q, height_d;
    logic             dim_valid_q, dim_valid_d;
    logic             ov_en_q, ov_en_d;
    logic [DIM_W-1:0] ov_x_q, ov_x_d, ov_y_q, ov_y_d;
    logic [1:0]       ch_q, ch_d;
    logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             d_qual_q, d_qual_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic [1:0]       chan_q, chan_d;
    logic             hb_last, ch_last, x_last, y_last;
    logic             in_x, in_y, ov_hit;
    idx_t             bit_idx;

    assign hb_last = (hb_q == HB_W'(HB - 1));
    assign ch_last = (ch_q == 2'(CHANNELS - 1));
    assign x_last  = (x_q == width_q - DIM_W'(1));
    assign y_last  = (y_q == height_q - DIM_W'(1));
    assign h_full  = (h_sh_q << DW) | DIM_W'(d_in);

    // Extended-width compares so a rectangle near the top of the range cannot wrap.
    always_comb begin
        in_x    = ({1'b0, x_q} >= {1'b0, ov_x_q}) &&
                  ({1'b0, x_q} < ({1'b0, ov_x_q} + ext_t'(OV_W)));
        in_y    = ({1'b0, y_q} >= {1'b0, ov_y_q}) &&
                  ({1'b0, y_q} < ({1'b0, ov_y_q} + ext_t'(OV_H)));
        bit_idx = idx_t'(y_q - ov_y_q) * idx_t'(OV_W) + idx_t'(x_q - ov_x_q);
        ov_hit  = ov_en_q && in_x && in_y && ov_bitmap[bit_idx];
    end

    always_comb begin
        state_d     = state_q;
        hb_d        = hb_q;
        w_sh_d      = w_sh_q;
        h_sh_d      = h_sh_q;
        width_d     = width_q;
        height_d    = height_q;
        dim_valid_d = dim_valid_q;
        ov_en_d     = ov_en_q;
        ov_x_d      = ov_x_q;
        ov_y_d      = ov_y_q;
        ch_d        = ch_q;
        x_d         = x_q;
        y_d         = y_q;
        frame_cnt_d = frame_cnt_q;
        d_qual_d    = 1'b0;
        dout_d      = dout_q;
        chan_d      = chan_q;
        sof_d       = 1'b0;
        eol_d       = 1'b0;
        eof_d       = 1'b0;
        if (pxq) begin
            unique case (state_q)
                StHdrW: begin
                    w_sh_d      = (w_sh_q << DW) | DIM_W'(d_in);
                    dim_valid_d = 1'b0;
                    hb_d        = hb_last ? '0 : hb_q + HB_W'(1);
                    if (hb_last) state_d = StHdrH;
                end
                StHdrH: begin
                    h_sh_d = h_full;
                    hb_d   = hb_last ? '0 : hb_q + HB_W'(1);
                    if (hb_last) begin
                        if (w_sh_q == '0 || h_full == '0) begin
                            state_d = StHdrW;
                        end else begin
                            state_d     = StPix;
                            width_d     = w_sh_q;
                            height_d    = h_full;
                            dim_valid_d = 1'b1;
                            ov_en_d     = ov_en;
                            ov_x_d      = ov_x;
                            ov_y_d      = ov_y;
                            ch_d        = '0;
                            x_d         = '0;
                            y_d         = '0;
                        end
                    end
                end
                StPix: begin
                    d_qual_d = 1'b1;
                    dout_d   = ov_hit ? OV_FG : d_in;
                    chan_d   = ch_q;
                    sof_d    = (x_q == '0) && (y_q == '0) && (ch_q == '0);
                    eol_d    = x_last && ch_last;
                    eof_d    = x_last && ch_last && y_last;
                    if (!ch_last) begin
                        ch_d = ch_q + 2'd1;
                    end else begin
                        ch_d = '0;
                        if (!x_last) begin
                            x_d = x_q + DIM_W'(1);
                        end else begin
                            x_d = '0;
                            if (!y_last) begin
                                y_d = y_q + DIM_W'(1);
                            end else begin
                                y_d         = '0;
                                state_d     = StHdrW;
                                frame_cnt_d = frame_cnt_q + 16'd1;
                            end
                        end
                    end
                end
                default: state_d = StHdrW;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= StHdrW;
            hb_q        <= '0;
            w_sh_q      <= '0;
            h_sh_q      <= '0;
            width_q     <= '0;
            height_q    <= '0;
            dim_valid_q <= 1'b0;
            ov_en_q     <= 1'b0;
            ov_x_q      <= '0;
            ov_y_q      <= '0;
            ch_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            frame_cnt_q <= '0;
            d_qual_q    <= 1'b0;
            dout_q      <= '0;
            chan_q      <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hb_q        <= hb_d;
            w_sh_q      <= w_sh_d;
            h_sh_q      <= h_sh_d;
            width_q     <= width_d;
            height_q    <= height_d;
            dim_valid_q <= dim_valid_d;
            ov_en_q     <= ov_en_d;
            ov_x_q      <= ov_x_d;
            ov_y_q      <= ov_y_d;
            ch_q        <= ch_d;
            x_q         <= x_d;
            y_q         <= y_d;
            frame_cnt_q <= frame_cnt_d;
            d_qual_q    <= d_qual_d;
            dout_q      <= dout_d;
            chan_q      <= chan_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            eof_q       <= eof_d;
        end
    end

    assign line_width       = width_q;
    assign pic_height       = height_q;
    assign dimensions_valid = dim_valid_q;
    assign d_qual           = d_qual_q;
    assign dout             = dout_q;
    assign chan             = chan_q;
    assign sof              = sof_q;
    assign eol              = eol_q;
    assign eof              = eof_q;
    assign frame_cnt        = frame_cnt_q;

endmodule

// File: tb/tb_imager_stream_parser.sv
// Self-checking bench for imager_stream_parser: table of frame cases plus hand-written
// back-to-back and mid-frame reset sequences; pixel outputs checked via a scoreboard queue.
module tb_imager_stream_parser;

    localparam int unsigned OV_W = 64;
    localparam int unsigned OV_H = 8;

    logic            clk_in = 1'b0;
    logic            rst;
    logic            pxq;
    logic [7:0]      d_in;
    logic            ov_en;
    logic [31:0]     ov_x, ov_y;
    logic [511:0]    ov_bitmap;
    logic [31:0]     line_width, pic_height;
    logic            dimensions_valid, d_qual, sof, eol, eof;
    logic [7:0]      dout;
    logic [1:0]      chan;
    logic [15:0]     frame_cnt;

    imager_stream_parser dut (
        .clk_in           (clk_in),
        .rst              (rst),
        .pxq              (pxq),
        .d_in             (d_in),
        .ov_en            (ov_en),
        .ov_x             (ov_x),
        .ov_y             (ov_y),
        .ov_bitmap        (ov_bitmap),
        .line_width       (line_width),
        .pic_height       (pic_height),
        .dimensions_valid (dimensions_valid),
        .d_qual           (d_qual),
        .dout             (dout),
        .chan             (chan),
        .sof              (sof),
        .eol              (eol),
        .eof              (eof),
        .frame_cnt        (frame_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0]  d;
        logic [1:0]  ch;
        logic        sof, eol, eof;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        int unsigned w, h;
        logic        ov_en;
        int unsigned ox, oy;
        logic        gap;
        logic        exp_dv;
        int unsigned exp_cnt;
    } case_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clk_in) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every qualified output must match the oldest pending expectation,
    // exactly one cycle after its beat was driven.
    always @(negedge clk_in) begin
        exp_t e;
        if (!rst && d_qual) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_dqual: got dout=%h chan=%0d, required no output", dout,
                         chan);
            end else begin
                e = sb.pop_front();
                if ({dout, chan, sof, eol, eof} !== {e.d, e.ch, e.sof, e.eol, e.eof} ||
                    cyc != e.cyc) begin
                    n_errors++;
                    $display("FAIL pixel: got d=%h ch=%0d sof=%b eol=%b eof=%b cyc=%0d, required d=%h ch=%0d sof=%b eol=%b eof=%b cyc=%0d",
                             dout, chan, sof, eol, eof, cyc, e.d, e.ch, e.sof, e.eol, e.eof,
                             e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic gap);
        pxq  = 1'b1;
        d_in = d;
        step();
        pxq  = 1'b0;
        if (gap) step();
    endtask

    task automatic send_header(input logic [31:0] w, input logic [31:0] h, input logic gap);
        for (int b = 3; b >= 0; b--) beat(8'(w >> (8 * b)), gap);
        for (int b = 3; b >= 0; b--) beat(8'(h >> (8 * b)), gap);
    endtask

    function automatic exp_t model(input case_t c, input int unsigned i, input logic [7:0] d);
        exp_t        e;
        int unsigned ch = i % 3;
        int unsigned px = i / 3;
        int unsigned x  = px % c.w;
        int unsigned y  = px / c.w;
        logic        hit;
        hit = c.ov_en && x >= c.ox && x < c.ox + OV_W && y >= c.oy && y < c.oy + OV_H &&
              ov_bitmap[(y - c.oy) * OV_W + (x - c.ox)] === 1'b1;
        e.d   = hit ? 8'hFF : d;
        e.ch  = ch[1:0];
        e.sof = (i == 0);
        e.eol = (x == c.w - 1) && (ch == 2);
        e.eof = e.eol && (y == c.h - 1);
        e.cyc = cyc + 1;
        return e;
    endfunction

    // n == 0 sends the whole frame.
    task automatic send_pixels(input case_t c, input int unsigned base, input int unsigned n);
        int unsigned total = (n == 0) ? c.w * c.h * 3 : n;
        for (int unsigned i = 0; i < total; i++) begin
            sb.push_back(model(c, i, 8'(base + i)));
            beat(8'(base + i), c.gap);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && sb.size() != 0; k++) step();
        check("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_line_width", line_width, 0);
        check("rst_pic_height", pic_height, 0);
        check("rst_flags", {dimensions_valid, d_qual, sof, eol, eof, chan}, 0);
        check("rst_dout", dout, 0);
        check("rst_frame_cnt", frame_cnt, 0);
    endtask

    task automatic run_frame(input case_t c, input int unsigned base);
        ov_en = c.ov_en;
        ov_x  = c.ox;
        ov_y  = c.oy;
        send_header(c.w, c.h, c.gap);
        // Live overlay inputs change after the header; the frame must use the latched ones.
        ov_en = ~c.ov_en;
        ov_x  = c.ox + 2;
        ov_y  = c.oy + 1;
        check("dimensions_valid", dimensions_valid, c.exp_dv);
        if (c.exp_dv) begin
            check("line_width", line_width, c.w);
            check("pic_height", pic_height, c.h);
            send_pixels(c, base, 0);
        end
        drain();
        check("frame_cnt", frame_cnt, c.exp_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        case_t cases[9];
        case_t c;
        cases[0] = '{4, 2, 1'b0, 0, 0, 1'b0, 1'b1, 1};
        cases[1] = '{4, 2, 1'b0, 0, 0, 1'b1, 1'b1, 2};
        cases[2] = '{4, 2, 1'b1, 1, 1, 1'b0, 1'b1, 3};
        cases[3] = '{0, 5, 1'b0, 0, 0, 1'b0, 1'b0, 3};
        cases[4] = '{2, 1, 1'b0, 0, 0, 1'b0, 1'b1, 4};
        cases[5] = '{1, 3, 1'b1, 0, 0, 1'b0, 1'b1, 5};
        cases[6] = '{4, 3, 1'b1, 3, 1, 1'b1, 1'b1, 6};
        cases[7] = '{4, 3, 1'b1, 0, 0, 1'b0, 1'b1, 7};
        cases[8] = '{256, 1, 1'b1, 250, 0, 1'b0, 1'b1, 8};

        rst       = 1'b1;
        pxq       = 1'b0;
        d_in      = '0;
        ov_en     = 1'b0;
        ov_x      = '0;
        ov_y      = '0;
        ov_bitmap = '0;
        ov_bitmap[0]  = 1'b1;
        ov_bitmap[64] = 1'b1;
        ov_bitmap[66] = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++) run_frame(cases[i], 16 * i);

        // Back-to-back frames: next header starts the cycle after the last pixel.
        c = '{2, 1, 1'b0, 0, 0, 1'b0, 1'b1, 9};
        send_header(2, 1, 1'b0);
        send_pixels(c, 8'hA0, 0);
        check("b2b_dv_before", dimensions_valid, 1);
        beat(8'h00, 1'b0);
        check("b2b_dv_falls", dimensions_valid, 0);
        for (int b = 2; b >= 0; b--) beat(8'(32'd1 >> (8 * b)), 1'b0);
        for (int b = 3; b >= 0; b--) beat(8'(32'd1 >> (8 * b)), 1'b0);
        check("b2b_dv_rises", dimensions_valid, 1);
        check("b2b_frame_cnt_mid", frame_cnt, 9);
        c = '{1, 1, 1'b0, 0, 0, 1'b0, 1'b1, 10};
        send_pixels(c, 8'hC0, 0);
        drain();
        check("b2b_frame_cnt", frame_cnt, 10);

        // Reset in the middle of a frame, then a fresh frame.
        c = '{4, 2, 1'b0, 0, 0, 1'b0, 1'b1, 0};
        ov_en = 1'b0;
        send_header(4, 2, 1'b0);
        send_pixels(c, 8'h50, 5);
        step();
        check("pre_rst_drained", sb.size(), 0);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        step();
        rst = 1'b0;
        step();
        run_frame('{3, 2, 1'b1, 2, 1, 1'b0, 1'b1, 1}, 8'h70);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
